// File: rtl/wait_event_multi_pkg.sv
// Shared types and constants for the multi-channel wait-event block.
package wait_event_multi_pkg;

  typedef enum logic [2:0] {
    MODE_RISE     = 3'd0,
    MODE_FALL     = 3'd1,
    MODE_HIGH     = 3'd2,
    MODE_LOW      = 3'd3,
    MODE_ANY_EDGE = 3'd4
  } wem_mode_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORT   = 2'd2,
    ST_ERROR   = 2'd3
  } wem_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } wem_state_e;

  localparam logic [2:0] WEM_MODE_MAX = 3'd4;

endpackage

// File: rtl/wait_event_multi_edge_det.sv
// Per-channel sample/prev registers and mode-match evaluation.
// Optional 2-flop input synchroniser: WAIT_EVENT_MULTI_SYNC_EN.
module wait_event_edge_det
  import wait_event_multi_pkg::*;
#(
  parameter int WAIT_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WAIT_SIZE-1:0] wait_signals,
  input  wem_mode_e            mode,
  output logic [WAIT_SIZE-1:0] match_vec
);

  logic [WAIT_SIZE-1:0] s;
  logic [WAIT_SIZE-1:0] p;

`ifdef WAIT_EVENT_MULTI_SYNC_EN
  logic [WAIT_SIZE-1:0] sync1;
  logic [WAIT_SIZE-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= wait_signals;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = wait_signals;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= s;
  end

  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < WAIT_SIZE; i++) begin
      case (mode)
        MODE_RISE:     match_vec[i] =  s[i] & ~p[i];
        MODE_FALL:     match_vec[i] = ~s[i] &  p[i];
        MODE_HIGH:     match_vec[i] =  s[i];
        MODE_LOW:      match_vec[i] = ~s[i];
        MODE_ANY_EDGE: match_vec[i] =  s[i] ^  p[i];
        default:       match_vec[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/wait_event_multi.sv
// Wait-event engine: one command at a time, reports match/timeout/abort/error.
// Build option WAIT_EVENT_MULTI_SYNC_EN adds input synchronisers in the edge detector.
module wait_event_multi
  import wait_event_multi_pkg::*;
#(
  parameter int WAIT_SIZE     = 16,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int SEL_WIDTH     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WAIT_SIZE-1:0]     wait_signals,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SEL_WIDTH-1:0]     cmd_sel,
  input  logic [2:0]               cmd_mode,
  input  logic [TIMEOUT_WIDTH-1:0] cmd_timeout,
  input  logic                     abort,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_status,
  output logic [TIMEOUT_WIDTH-1:0] rsp_cycles,
  output logic                     busy
);

  wem_state_e               state, state_n;
  logic [SEL_WIDTH-1:0]     sel_q, sel_n;
  logic [2:0]               mode_q, mode_n;
  logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_n;
  logic [TIMEOUT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  wem_status_e              status_q, status_n;
  logic [TIMEOUT_WIDTH-1:0] cycles_q, cycles_n;
  logic                     init_q;
  logic [WAIT_SIZE-1:0]     match_vec;
  logic                     match;
  logic                     cmd_bad;

  wait_event_edge_det #(
    .WAIT_SIZE (WAIT_SIZE)
  ) u_edge_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .wait_signals (wait_signals),
    .mode         (wem_mode_e'(mode_q)),
    .match_vec    (match_vec)
  );

  // Loop-based select keeps out-of-range selectors safe for any SEL_WIDTH.
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < WAIT_SIZE; i++) begin
      if (SEL_WIDTH'(i) == sel_q) match = match_vec[i];
    end
  end

  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign cmd_bad   = (32'(cmd_sel) >= 32'(WAIT_SIZE)) || (cmd_mode > WEM_MODE_MAX);
  assign cmd_ready = init_q && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_status = status_q;
  assign rsp_cycles = cycles_q;

  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    mode_n    = mode_q;
    timeout_n = timeout_q;
    cnt_n     = cnt;
    status_n  = status_q;
    cycles_n  = cycles_q;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sel_n     = cmd_sel;
          mode_n    = cmd_mode;
          timeout_n = cmd_timeout;
          cnt_n     = '0;
          if (cmd_bad) begin
            state_n  = S_RESP;
            status_n = ST_ERROR;
            cycles_n = '0;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        if (abort) begin
          state_n  = S_RESP;
          status_n = ST_ABORT;
          cycles_n = cnt_inc;
        end else if (match) begin
          state_n  = S_RESP;
          status_n = ST_OK;
          cycles_n = cnt_inc;
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          state_n  = S_RESP;
          status_n = ST_TIMEOUT;
          cycles_n = cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      mode_q    <= '0;
      timeout_q <= '0;
      cnt       <= '0;
      status_q  <= ST_OK;
      cycles_q  <= '0;
      init_q    <= 1'b0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      mode_q    <= mode_n;
      timeout_q <= timeout_n;
      cnt       <= cnt_n;
      status_q  <= status_n;
      cycles_q  <= cycles_n;
      init_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wait_event_multi.sv
// Scoreboard bench for wait_event_multi: directed commands push expected responses,
// a monitor pops and compares on each response handshake.
module tb_wait_event_multi;
  import wait_event_multi_pkg::*;

`ifdef WAIT_EVENT_MULTI_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wait_signals;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_sel;
  logic [2:0]  cmd_mode;
  logic [31:0] cmd_timeout;
  logic        abort;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_cycles;
  logic        busy;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  wait_event_multi #(
    .WAIT_SIZE     (16),
    .TIMEOUT_WIDTH (32),
    .SEL_WIDTH     (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wait_signals (wait_signals),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_mode     (cmd_mode),
    .cmd_timeout  (cmd_timeout),
    .abort        (abort),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_status   (rsp_status),
    .rsp_cycles   (rsp_cycles),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(e.st));
        chk("rsp_cycles", 64'(rsp_cycles), 64'(e.cyc));
      end
    end
  end

  // Entry and exit: posedge + #1.
  task automatic issue(input logic [4:0] sel, input logic [2:0] mode, input logic [31:0] to);
    cmd_valid   = 1'b1;
    cmd_sel     = sel;
    cmd_mode    = mode;
    cmd_timeout = to;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] cyc);
    exp_t e;
    e.st  = st;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    wait_signals = '0;
    cmd_valid    = 1'b0;
    cmd_sel      = '0;
    cmd_mode     = '0;
    cmd_timeout  = '0;
    abort        = 1'b0;
    rsp_ready    = 1'b1;

    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("rst_rsp_cycles", 64'(rsp_cycles), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", 64'(cmd_ready), 64'd1);

    // 1: RISE on channel 3, edge 10 cycles after accept.
    issue(5'd3, MODE_RISE, 32'd100);
    expect_rsp(ST_OK, 32'(10 + LAT));
    repeat (9) @(posedge clk);
    #1 wait_signals[3] = 1'b1;
    wait_idle("t1_done");
    wait_signals = '0;
    repeat (4) @(posedge clk);
    #1;

    // 2: HIGH on a low channel times out.
    issue(5'd0, MODE_HIGH, 32'd5);
    expect_rsp(ST_TIMEOUT, 32'd5);
    @(negedge clk) chk("t2_busy_wait", 64'(busy), 64'd1);
    wait_idle("t2_busy_drop");

    // 3: FALL lands in the same cycle the timeout would fire; match wins.
    wait_signals[5] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(5'd5, MODE_FALL, 32'd4);
    expect_rsp(ST_OK, 32'd4);
    repeat (3 - LAT) @(posedge clk);
    #1 wait_signals[5] = 1'b0;
    wait_idle("t3_done");
    repeat (4) @(posedge clk);
    #1;

    // 4: abort at cycle 7 of an infinite wait, then abort in IDLE.
    issue(5'd2, MODE_ANY_EDGE, 32'd0);
    expect_rsp(ST_ABORT, 32'd7);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle("t4_done");
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    issue(5'd1, MODE_LOW, 32'd0);
    expect_rsp(ST_OK, 32'd1);
    wait_idle("t4_low_done");

    // 5: invalid selector and reserved mode go straight to ERROR.
    issue(5'd20, MODE_RISE, 32'd10);
    expect_rsp(ST_ERROR, 32'd0);
    @(negedge clk) chk("t5_sel_direct_resp", 64'(rsp_valid), 64'd1);
    wait_idle("t5_sel_done");
    issue(5'd2, 3'd6, 32'd10);
    expect_rsp(ST_ERROR, 32'd0);
    @(negedge clk) chk("t5_mode_direct_resp", 64'(rsp_valid), 64'd1);
    wait_idle("t5_mode_done");
    issue(5'd15, MODE_HIGH, 32'd3);
    expect_rsp(ST_TIMEOUT, 32'd3);
    wait_idle("t5_sel15_done");

    // 6a: reset mid-WAIT.
    issue(5'd4, MODE_RISE, 32'd0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 6b: response held under backpressure.
    rsp_ready = 1'b0;
    wait_signals[6] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(5'd6, MODE_HIGH, 32'd0);
    expect_rsp(ST_OK, 32'd1);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t6_hold_status", 64'(rsp_status), 64'(ST_OK));
      chk("t6_hold_cycles", 64'(rsp_cycles), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle("t6_done");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
